pwm_deadtime: RTL and testbench
===============================

PWM_DEADTIME -- requirements
Module: pwm_deadtime

Interface
REQ-001 The module SHALL have parameter CHANNELS, default 2, giving the number of PWM channels.
REQ-002 The module SHALL have parameter DT_BITS, default 4, giving the width of the dead-time count.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port pwm_in, input, CHANNELS bits: raw PWM from the upstream PWM controller, synchronous to clk.
REQ-006 The module SHALL have port channel_enable, input, CHANNELS bits: per-channel enable.
REQ-007 The module SHALL have port dead_time, input, DT_BITS bits: dead interval in clk cycles, shared by all channels.
REQ-008 The module SHALL have port out_hi, output, CHANNELS bits: high-side gate drive, registered.
REQ-009 The module SHALL have port out_lo, output, CHANNELS bits: low-side gate drive, registered.

Function
REQ-010 Each channel SHALL run an independent FSM with states OFF, LOW, DT_RISE, HIGH and DT_FALL, plus its own DT_BITS-bit down-counter cnt.
REQ-011 Outputs SHALL decode from the state register only: HIGH gives out_hi=1; LOW gives out_lo=1; OFF, DT_RISE and DT_FALL give both outputs 0.
REQ-012 out_hi[i] and out_lo[i] SHALL never both be 1 in any cycle, including across reset, enable and dead_time changes.
REQ-013 In any state, channel_enable[i]=0 SHALL force the channel to OFF at the next edge; this rule has priority over all other transitions.
REQ-014 From OFF with the channel enabled, the FSM SHALL go to LOW.
REQ-015 From LOW with pwm_in=1, the FSM SHALL go to HIGH if dead_time=0; otherwise it SHALL go to DT_RISE and load cnt with dead_time.
REQ-016 In DT_RISE, pwm_in=0 SHALL return the FSM to LOW (pulse shorter than dead time is absorbed); else cnt=1 SHALL move it to HIGH; else cnt SHALL decrement.
REQ-017 From HIGH with pwm_in=0, the FSM SHALL go to LOW if dead_time=0; otherwise it SHALL go to DT_FALL and load cnt with dead_time.
REQ-018 In DT_FALL, pwm_in=1 SHALL return the FSM to HIGH; else cnt=1 SHALL move it to LOW; else cnt SHALL decrement.
REQ-019 dead_time SHALL be sampled only on entry to DT_RISE or DT_FALL; changes during an interval SHALL not affect that interval.
REQ-020 Latency SHALL be as follows: with pwm_in sampled high at edge N, out_hi SHALL be 1 after edge N+D for dead_time=D≥1, and after edge N for D=0; the falling edge is symmetric on out_lo.
REQ-021 Both sides off SHALL last exactly D cycles per complete transition.

Reset
REQ-022 While rst=0, every channel SHALL be in OFF, cnt=0, and out_hi=out_lo=0, asynchronously.
REQ-023 After rst is released, the first edge SHALL apply REQ-014; reset asserted mid-interval SHALL abort the interval to OFF immediately.

Configuration
REQ-024 Macro PWM_DEADTIME_FAULT_EN SHALL, when defined, add these ports: fault (input, 1 bit), fault_clear (input, 1 bit) and fault_active (output, 1 bit, registered, reset 0).
REQ-025 With PWM_DEADTIME_FAULT_EN defined, fault=1 sampled at an edge SHALL set fault_active=1 and force all channels to OFF at that edge, with priority over channel_enable.
REQ-026 With PWM_DEADTIME_FAULT_EN defined, fault_active SHALL hold channels in OFF until an edge with fault_clear=1 and fault=0; fault_active SHALL then clear and channels SHALL resume per REQ-014.
REQ-027 Without PWM_DEADTIME_FAULT_EN, those ports and that logic SHALL be absent, and behaviour SHALL be exactly REQ-010 to REQ-023.

Verification
REQ-028 The bench SHALL cover: dead_time=3, enable=1, pwm_in toggling with an 8-cycle period at 50% -> out_hi high 1 cycle, out_lo high 1 cycle, and 3-cycle both-low gaps between them.
REQ-029 The bench SHALL cover: dead_time=0, same stimulus -> out_hi mirrors pwm_in delayed 1 cycle and out_lo is its complement, with no gap.
REQ-030 The bench SHALL cover: dead_time=4 with a 2-cycle pwm_in pulse -> out_hi stays 0 and out_lo drops only during the pulse window, never overlapping out_hi.
REQ-031 The bench SHALL cover: channel_enable 11->01 mid-HIGH on channel 1 -> channel 1 goes to both outputs 0 at the next edge while channel 0 is unaffected.
REQ-032 The bench SHALL cover: rst=0 asserted during DT_RISE -> all outputs 0 immediately, then LOW one edge after release.
REQ-033 The bench SHALL cover (with PWM_DEADTIME_FAULT_EN defined): fault pulse of 1 cycle -> all outputs 0 and fault_active=1; both stay that way until fault_clear=1, and then the channels resume in LOW.

Source files
------------

// File: rtl/pwm_deadtime.sv
// Complementary gate-drive generator with per-channel dead-time insertion.
// Optional latched fault shutdown is compiled in with `define PWM_DEADTIME_FAULT_EN.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_OFF     | channel disabled or held by fault/reset; both gates off
// ST_LOW     | low-side gate on
// ST_DT_RISE | dead interval before turning the high side on; both off
// ST_HIGH    | high-side gate on
// ST_DT_FALL | dead interval before turning the low side on; both off
module pwm_deadtime #(
  parameter int CHANNELS = 2,
  parameter int DT_BITS  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] pwm_in,
  input  logic [CHANNELS-1:0] channel_enable,
  input  logic [DT_BITS-1:0]  dead_time,
`ifdef PWM_DEADTIME_FAULT_EN
  input  logic                fault,
  input  logic                fault_clear,
  output logic                fault_active,
`endif
  output logic [CHANNELS-1:0] out_hi,
  output logic [CHANNELS-1:0] out_lo
);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_LOW     = 3'd1,
    ST_DT_RISE = 3'd2,
    ST_HIGH    = 3'd3,
    ST_DT_FALL = 3'd4
  } state_e;

  state_e              state_q [CHANNELS];
  state_e              state_d [CHANNELS];
  logic [DT_BITS-1:0]  cnt_q   [CHANNELS];
  logic [DT_BITS-1:0]  cnt_d   [CHANNELS];
  logic [CHANNELS-1:0] out_hi_q, out_hi_d;
  logic [CHANNELS-1:0] out_lo_q, out_lo_d;
  logic                force_off;

`ifdef PWM_DEADTIME_FAULT_EN
  logic fault_active_q, fault_active_d;

  // A fault asserted in the same cycle as a clear wins; channels stay off
  // through the clearing edge and restart from OFF on the following one.
  always_comb begin
    fault_active_d = fault_active_q;
    if (fault) begin
      fault_active_d = 1'b1;
    end else if (fault_clear) begin
      fault_active_d = 1'b0;
    end
  end

  assign force_off    = fault | fault_active_q;
  assign fault_active = fault_active_q;
`else
  assign force_off = 1'b0;
`endif

  always_comb begin
    out_hi_d = '0;
    out_lo_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (force_off || !channel_enable[i]) begin
        state_d[i] = ST_OFF;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          ST_OFF: begin
            state_d[i] = ST_LOW;
          end
          ST_LOW: begin
            if (pwm_in[i]) begin
              if (dead_time == '0) begin
                state_d[i] = ST_HIGH;
              end else begin
                state_d[i] = ST_DT_RISE;
                cnt_d[i]   = dead_time;
              end
            end
          end
          ST_DT_RISE: begin
            if (!pwm_in[i]) begin
              state_d[i] = ST_LOW;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == DT_BITS'(1)) begin
              state_d[i] = ST_HIGH;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] - DT_BITS'(1);
            end
          end
          ST_HIGH: begin
            if (!pwm_in[i]) begin
              if (dead_time == '0) begin
                state_d[i] = ST_LOW;
              end else begin
                state_d[i] = ST_DT_FALL;
                cnt_d[i]   = dead_time;
              end
            end
          end
          ST_DT_FALL: begin
            if (pwm_in[i]) begin
              state_d[i] = ST_HIGH;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == DT_BITS'(1)) begin
              state_d[i] = ST_LOW;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] - DT_BITS'(1);
            end
          end
          default: begin
            state_d[i] = ST_OFF;
            cnt_d[i]   = '0;
          end
        endcase
      end
      // Gate drives are a pure decode of the next state, so each output flop
      // always mirrors its state flop and the two sides can never overlap.
      out_hi_d[i] = (state_d[i] == ST_HIGH);
      out_lo_d[i] = (state_d[i] == ST_LOW);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= ST_OFF;
        cnt_q[i]   <= '0;
      end
      out_hi_q <= '0;
      out_lo_q <= '0;
`ifdef PWM_DEADTIME_FAULT_EN
      fault_active_q <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      out_hi_q <= out_hi_d;
      out_lo_q <= out_lo_d;
`ifdef PWM_DEADTIME_FAULT_EN
      fault_active_q <= fault_active_d;
`endif
    end
  end

  assign out_hi = out_hi_q;
  assign out_lo = out_lo_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Randomized and directed bench for pwm_deadtime against a streak-counting reference.
// Fault scenarios run only when PWM_DEADTIME_FAULT_EN is defined.
module tb_pwm_deadtime;
  localparam int CH  = 2;
  localparam int DTB = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [CH-1:0]  pwm_in = '0;
  logic [CH-1:0]  channel_enable = '0;
  logic [DTB-1:0] dead_time = '0;
  logic [CH-1:0]  out_hi;
  logic [CH-1:0]  out_lo;
`ifdef PWM_DEADTIME_FAULT_EN
  logic           fault = 1'b0;
  logic           fault_clear = 1'b0;
  logic           fault_active;
`endif

  pwm_deadtime #(.CHANNELS(CH), .DT_BITS(DTB)) dut (
    .clk            (clk),
    .rst            (rst),
    .pwm_in         (pwm_in),
    .channel_enable (channel_enable),
    .dead_time      (dead_time),
`ifdef PWM_DEADTIME_FAULT_EN
    .fault          (fault),
    .fault_clear    (fault_clear),
    .fault_active   (fault_active),
`endif
    .out_hi         (out_hi),
    .out_lo         (out_lo)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: a channel holds a committed side; the side flips once the input
  // has disagreed with it for dead_time+1 consecutive samples (dead_time taken
  // when the disagreement began). While disagreeing, both gates are off.
  bit m_on     [CH];
  bit m_cur    [CH];
  int m_streak [CH];
  int m_d      [CH];
  bit m_fault;

  function automatic void model_reset();
    for (int i = 0; i < CH; i++) begin
      m_on[i] = 0; m_cur[i] = 0; m_streak[i] = 0; m_d[i] = 0;
    end
    m_fault = 0;
  endfunction

  function automatic void model_edge();
    bit hold;
    if (!rst) begin
      model_reset();
      return;
    end
    hold = 0;
`ifdef PWM_DEADTIME_FAULT_EN
    hold = fault || m_fault;
    if (fault) m_fault = 1;
    else if (fault_clear) m_fault = 0;
`endif
    for (int i = 0; i < CH; i++) begin
      if (hold || !channel_enable[i]) begin
        m_on[i] = 0;
      end else if (!m_on[i]) begin
        m_on[i] = 1; m_cur[i] = 0; m_streak[i] = 0;
      end else if (pwm_in[i] == m_cur[i]) begin
        m_streak[i] = 0;
      end else begin
        if (m_streak[i] == 0) m_d[i] = int'(dead_time);
        m_streak[i]++;
        if (m_streak[i] > m_d[i]) begin
          m_cur[i] = !m_cur[i];
          m_streak[i] = 0;
        end
      end
    end
  endfunction

  function automatic logic [CH-1:0] exp_hi();
    logic [CH-1:0] v;
    for (int i = 0; i < CH; i++) v[i] = m_on[i] && m_streak[i] == 0 && m_cur[i];
    return v;
  endfunction

  function automatic logic [CH-1:0] exp_lo();
    logic [CH-1:0] v;
    for (int i = 0; i < CH; i++) v[i] = m_on[i] && m_streak[i] == 0 && !m_cur[i];
    return v;
  endfunction

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, "_hi"}, 32'(out_hi), 32'(exp_hi()));
    chk({tag, "_lo"}, 32'(out_lo), 32'(exp_lo()));
    chk({tag, "_overlap"}, 32'(out_hi & out_lo), 32'd0);
`ifdef PWM_DEADTIME_FAULT_EN
    chk({tag, "_fault_active"}, 32'(fault_active), 32'(m_fault));
`endif
  endtask

  task automatic async_reset_pulse(input string tag);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk({tag, "_async_hi"}, 32'(out_hi), 32'd0);
    chk({tag, "_async_lo"}, 32'(out_lo), 32'd0);
  endtask

  int hi_cnt, lo_cnt, lo_gap;

  initial begin
    model_reset();
    #1 rst = 1'b0;
    #1;
    chk("reset_hi", 32'(out_hi), 32'd0);
    chk("reset_lo", 32'(out_lo), 32'd0);
    cycle("in_reset");
    rst = 1'b1;
    channel_enable = 2'b11;
    dead_time = 4'd3;
    cycle("first_edge");
    chk("first_edge_low", 32'(out_lo), 32'h3);

    // 8-cycle 50% PWM with dead_time 3
    hi_cnt = 0; lo_cnt = 0;
    for (int k = 0; k < 32; k++) begin
      pwm_in = ((k % 8) < 4) ? 2'b11 : 2'b00;
      cycle("dt3");
      if (k >= 16 && k < 24) begin
        hi_cnt += int'(out_hi[0]);
        lo_cnt += int'(out_lo[0]);
      end
    end
    chk("dt3_hi_cycles", 32'(hi_cnt), 32'd1);
    chk("dt3_lo_cycles", 32'(lo_cnt), 32'd1);

    // Same stimulus, no dead time
    dead_time = 4'd0;
    hi_cnt = 0; lo_cnt = 0;
    for (int k = 0; k < 32; k++) begin
      pwm_in = ((k % 8) < 4) ? 2'b11 : 2'b00;
      cycle("dt0");
      if (k >= 16 && k < 24) begin
        hi_cnt += int'(out_hi[0]);
        lo_cnt += int'(out_lo[0]);
        chk("dt0_mirror", 32'(out_hi[0]), 32'(pwm_in[0]));
      end
    end
    chk("dt0_hi_cycles", 32'(hi_cnt), 32'd4);
    chk("dt0_lo_cycles", 32'(lo_cnt), 32'd4);

    // Pulse shorter than dead time is absorbed
    dead_time = 4'd4;
    pwm_in = 2'b00;
    for (int k = 0; k < 6; k++) cycle("dt4_settle");
    hi_cnt = 0; lo_gap = 0;
    for (int k = 0; k < 10; k++) begin
      pwm_in = (k < 2) ? 2'b11 : 2'b00;
      cycle("dt4_pulse");
      hi_cnt += int'(out_hi[0]);
      lo_gap += int'(!out_lo[0]);
    end
    chk("short_pulse_hi", 32'(hi_cnt), 32'd0);
    chk("short_pulse_lo_gap", 32'(lo_gap), 32'd2);

    // Drop channel 1 while both are high
    dead_time = 4'd0;
    pwm_in = 2'b11;
    for (int k = 0; k < 3; k++) cycle("pre_drop");
    channel_enable = 2'b01;
    cycle("en_drop");
    chk("en_drop_hi", 32'(out_hi), 32'h1);
    chk("en_drop_lo", 32'(out_lo), 32'h0);
    channel_enable = 2'b11;
    for (int k = 0; k < 3; k++) cycle("re_enable");

    // Reset in the middle of a rising dead interval
    dead_time = 4'd5;
    pwm_in = 2'b00;
    for (int k = 0; k < 8; k++) cycle("pre_rst");
    pwm_in = 2'b11;
    for (int k = 0; k < 2; k++) cycle("dt_rise");
    async_reset_pulse("mid_dt");
    cycle("held_rst");
    cycle("held_rst");
    rst = 1'b1;
    cycle("rst_rel");
    chk("rst_rel_lo", 32'(out_lo), 32'h3);
    chk("rst_rel_hi", 32'(out_hi), 32'h0);

`ifdef PWM_DEADTIME_FAULT_EN
    dead_time = 4'd2;
    for (int k = 0; k < 12; k++) begin
      pwm_in = ((k % 8) < 4) ? 2'b11 : 2'b00;
      cycle("pre_fault");
    end
    fault = 1'b1;
    cycle("fault_edge");
    fault = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pwm_in = ~pwm_in;
      cycle("fault_hold");
      chk("fault_hold_out", 32'({out_hi, out_lo}), 32'd0);
      chk("fault_hold_flag", 32'(fault_active), 32'd1);
    end
    fault_clear = 1'b1;
    pwm_in = 2'b00;
    cycle("fault_clear");
    fault_clear = 1'b0;
    cycle("fault_resume");
    chk("fault_resume_lo", 32'(out_lo), 32'h3);
    chk("fault_resume_flag", 32'(fault_active), 32'd0);
`endif

    // Randomized run, with dead_time and enable churn and occasional resets
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 3) == 0) pwm_in[i] = ~pwm_in[i];
      if ($urandom_range(0, 7) == 0) dead_time = DTB'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) channel_enable = CH'($urandom_range(0, 3));
      else if ($urandom_range(0, 9) == 0) channel_enable = 2'b11;
`ifdef PWM_DEADTIME_FAULT_EN
      fault = ($urandom_range(0, 59) == 0);
      fault_clear = ($urandom_range(0, 7) == 0);
`endif
      if ($urandom_range(0, 99) == 0) begin
        async_reset_pulse("rand_rst");
        #1 rst = 1'b1;
      end
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
